calc_disp_sched: RTL and testbench

Display scheduler for the calculator datapath. It accepts a binary result or operand from the calc FSM through a req/ack handshake and converts it to BCD by iterative double-dabble. It then sequences the digits onto the shared data/pos display bus, one digit per cycle, with leading-zero blanking, a minus sign, and error/overflow codes. It replaces the inline divide-by-10 display loop: the calc core only raises req and waits for done.

---
 rtl/calc_disp_sched.sv | 174 +++++++++++++++++
 tb/tb_calc_disp_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_disp_sched.sv
// Display scheduler: latches a binary operand and converts it to BCD by iterative double-dabble.
// It then streams one display code per cycle onto the shared data/pos bus.
// Latency: ack 1 cycle after accept; normal path done at WIDTH+DIGITS+1; err path done at DIGITS+1.
// Backpressure: none downstream; req is ignored while busy, and a new req is accepted in IDLE or in FIN.
//
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   req/value/neg/err   : display request and operands from the calc FSM
//   ack, busy, done     : handshake (ack/done are one-cycle pulses)
//   data, pos, dvalid   : display bus; data codes 0-9 BCD, A minus, E error, F blank
module calc_disp_sched #(
  parameter int WIDTH  = 27,
  parameter int DIGITS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req,
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  input  logic             err,
  output logic             ack,
  output logic             busy,
  output logic [3:0]       data,
  output logic [3:0]       pos,
  output logic             dvalid,
  output logic             done
);

  localparam int BW = DIGITS * 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [4:0] LAST_IT  = 5'(WIDTH - 1);
  localparam logic [4:0] LAST_POS = 5'(DIGITS - 1);

  logic [1:0]       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;    // iteration counter in CONV, position counter in SCAN
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             neg_q, neg_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;    // sticky: a 1 left the top BCD nibble
  logic             ack_q, ack_d;

  logic [BW-1:0]    bcd_adj;
  logic             accept;

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // FIN doubles as an accept slot so a held req restarts immediately after done.
  assign accept = req && ((state_q == S_IDLE) || (state_q == S_FIN));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    ack_d   = 1'b0;

    case (state_q)
      S_CONV: begin
        bcd_d = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        ovf_d = ovf_q | bcd_adj[BW-1];
        if (cnt_q == LAST_IT) begin
          cnt_d   = 5'd0;
          state_d = S_SCAN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_SCAN: begin
        if (cnt_q == LAST_POS) begin
          cnt_d   = 5'd0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: ;
    endcase

    // Capture clears the BCD register so a previous result never leaks through.
    if (accept) begin
      ack_d   = 1'b1;
      bin_d   = value;
      neg_d   = neg;
      err_d   = err;
      ovf_d   = 1'b0;
      bcd_d   = '0;
      cnt_d   = 5'd0;
      state_d = err ? S_SCAN : S_CONV;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      bin_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
    end
  end

  // Display code for the position currently being scanned.
  logic [3:0] scan_pos;
  logic [3:0] msd;       // index of most significant nonzero digit (0 if value is 0)
  logic [3:0] digit;
  logic       err_pat;
  logic [3:0] code;

  assign scan_pos = cnt_q[3:0];

  always_comb begin
    msd   = 4'd0;
    digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] != 4'd0) msd = 4'(i);
      if (4'(i) == scan_pos) digit = bcd_q[i*4 +: 4];
    end
  end

  // A negative number needs a free position above its top digit for the sign.
  assign err_pat = err_q || ovf_q || (neg_q && (bcd_q[BW-1 -: 4] != 4'd0));

  always_comb begin
    code = 4'hF;
    if (err_pat) begin
      code = (scan_pos == 4'd0) ? 4'hE : 4'hF;
    end else if (scan_pos <= msd) begin
      code = digit;
    end else if (neg_q && (scan_pos == msd + 4'd1)) begin
      code = 4'hA;
    end
  end

  assign ack    = ack_q;
  assign busy   = (state_q == S_CONV) || (state_q == S_SCAN);
  assign dvalid = (state_q == S_SCAN);
  assign done   = (state_q == S_FIN);
  assign pos    = dvalid ? scan_pos : 4'd0;
  assign data   = dvalid ? code : 4'hF;

endmodule

// File: tb/tb_calc_disp_sched.sv
// Directed bench for calc_disp_sched: runs hand-computed display sequences and checks codes and timing.
// Codes are packed pos0 in the low nibble, so 32'hFFF12345 reads as the display shows it.
// Every check goes through chk(); a global time limit ends the run if the design stalls.
module tb_calc_disp_sched;

  logic        clock;
  logic        reset;
  logic        req;
  logic [26:0] value;
  logic        neg;
  logic        err;
  logic        ack;
  logic        busy;
  logic [3:0]  data;
  logic [3:0]  pos;
  logic        dvalid;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  calc_disp_sched #(.WIDTH(27), .DIGITS(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .value  (value),
    .neg    (neg),
    .err    (err),
    .ack    (ack),
    .busy   (busy),
    .data   (data),
    .pos    (pos),
    .dvalid (dvalid),
    .done   (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called right after the accepting edge. Watches cycles 1.. until done or a 60-cycle bound.
  task automatic monitor(input string tag, input logic [31:0] exp_codes, input int exp_done,
                         input bit drop_req, input bit glitch);
    logic [31:0] codes;
    int          first_dv;
    int          dv_cnt;
    int          done_cyc;
    int          ack_cnt;
    int          busy_bad;
    codes    = 32'h0;
    first_dv = -1;
    dv_cnt   = 0;
    done_cyc = -1;
    ack_cnt  = 0;
    busy_bad = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (c == 1) begin
        chk({tag, "_ack1"}, {31'd0, ack}, 32'd1);
        if (drop_req) req = 1'b0;
        value = value ^ 27'h5A5A5A5;  // must not disturb the captured operand
      end
      if (ack) ack_cnt++;
      if (busy !== (c < exp_done)) busy_bad++;
      if (dvalid) begin
        if (first_dv < 0) first_dv = c;
        codes[pos*4 +: 4] = data;
        dv_cnt++;
      end
      if (glitch && c == 5) begin
        req   = 1'b1;
        value = 27'd777;
        neg   = 1'b1;
      end
      if (glitch && c == 6) begin
        req = 1'b0;
        neg = 1'b0;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    chk({tag, "_codes"}, codes, exp_codes);
    chk({tag, "_first_dv"}, 32'(first_dv), 32'(exp_done - 8));
    chk({tag, "_dv_cnt"}, 32'(dv_cnt), 32'd8);
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_ack_cnt"}, 32'(ack_cnt), 32'd1);
    chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
  endtask

  task automatic run_seq(input string tag, input logic [26:0] v, input logic n, input logic e,
                         input logic [31:0] exp_codes, input int exp_done);
    @(negedge clock);
    value = v;
    neg   = n;
    err   = e;
    req   = 1'b1;
    @(posedge clock);
    monitor(tag, exp_codes, exp_done, 1'b1, 1'b0);
    err = 1'b0;
    neg = 1'b0;
  endtask

  initial begin
    int dones;
    reset = 1'b0;
    req   = 1'b0;
    value = 27'd0;
    neg   = 1'b0;
    err   = 1'b0;
    #12;
    chk("rst_ack",    {31'd0, ack},    32'd0);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_dvalid", {31'd0, dvalid}, 32'd0);
    chk("rst_done",   {31'd0, done},   32'd0);
    chk("rst_data",   {28'd0, data},   32'hF);
    chk("rst_pos",    {28'd0, pos},    32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    run_seq("v12345",   27'd12345,     1'b0, 1'b0, 32'hFFF12345, 36);
    run_seq("v0",       27'd0,         1'b0, 1'b0, 32'hFFFFFFF0, 36);
    run_seq("v9s",      27'd99999999,  1'b0, 1'b0, 32'h99999999, 36);
    run_seq("ovf",      27'd100000000, 1'b0, 1'b0, 32'hFFFFFFFE, 36);
    run_seq("ovfmax",   27'h7FFFFFF,   1'b0, 1'b0, 32'hFFFFFFFE, 36);
    run_seq("neg42",    27'd42,        1'b1, 1'b0, 32'hFFFFFA42, 36);
    run_seq("neg7dig",  27'd1234567,   1'b1, 1'b0, 32'hA1234567, 36);
    run_seq("negovf",   27'd12345678,  1'b1, 1'b0, 32'hFFFFFFFE, 36);
    run_seq("err7",     27'd7,         1'b0, 1'b1, 32'hFFFFFFFE, 9);
    run_seq("errneg",   27'd55,        1'b1, 1'b1, 32'hFFFFFFFE, 9);

    // req held high: one acceptance per sequence, re-accept on the FIN edge.
    @(negedge clock);
    value = 27'd305;
    req   = 1'b1;
    @(posedge clock);
    monitor("hold1", 32'hFFFFF305, 36, 1'b0, 1'b0);
    value = 27'd305;
    @(posedge clock);
    monitor("hold2", 32'hFFFFF305, 36, 1'b1, 1'b0);

    // req pulse with a different value during CONV is ignored.
    @(negedge clock);
    value = 27'd8642;
    req   = 1'b1;
    @(posedge clock);
    monitor("glitch", 32'hFFFF8642, 36, 1'b1, 1'b1);

    // Asynchronous reset mid-CONV.
    @(negedge clock);
    value = 27'd12345;
    req   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    chk("arst_pre_busy", {31'd0, busy}, 32'd1);
    repeat (9) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy",   {31'd0, busy},   32'd0);
    chk("arst_ack",    {31'd0, ack},    32'd0);
    chk("arst_dvalid", {31'd0, dvalid}, 32'd0);
    chk("arst_done",   {31'd0, done},   32'd0);
    chk("arst_data",   {28'd0, data},   32'hF);
    chk("arst_pos",    {28'd0, pos},    32'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (c == 2) reset = 1'b1;
      if (done || dvalid) dones++;
    end
    chk("arst_no_done", 32'(dones), 32'd0);
    run_seq("post_rst5", 27'd5, 1'b0, 1'b0, 32'hFFFFFFF5, 36);

    // Back-to-back: stale BCD from the first must not leak into the second.
    run_seq("b2b9",  27'd9,  1'b0, 1'b0, 32'hFFFFFFF9, 36);
    run_seq("b2b10", 27'd10, 1'b0, 1'b0, 32'hFFFFFF10, 36);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, got no completion, expected $finish");
    $fatal(1, "timeout");
  end

endmodule
